// File: rtl/rs232_rx.sv
// rs232_rx: 8N1 serial receiver in the CLKRS232 domain.
// Oversamples rxd on the rx_en strobe, checks the start bit at mid-bit and
// samples each data and stop bit one bit time later. Each good byte goes into a
// one-deep holding register with a ready/ack handshake.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line idle; waiting for rxd_s low on an rx_en
// S_START | counting to the middle of the start bit to confirm it
// S_DATA  | sampling DATABITS data bits, LSB first, one per bit time
// S_STOP  | sampling the stop bit; good -> load byte, low -> frame_err
// S_BREAK | stop bit was low; wait for the line to return high
module rs232_rx #(
  parameter int OVERSAMPLE = 8,
  parameter int DATABITS   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_en,
  input  logic                rxd,
  output logic [DATABITS-1:0] data_out,
  output logic                data_ready,
  input  logic                data_ack,
  output logic                frame_err,
  output logic                overrun
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATABITS > 1) ? $clog2(DATABITS) : 1;
  localparam logic [SW-1:0] HALF_M1  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_M1  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATABITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t                state, state_n;
  logic [SW-1:0]         sample_cnt, sample_n;
  logic [BW-1:0]         bit_cnt, bit_n;
  logic [DATABITS-1:0]   shift, shift_n;
  logic                  sync1, rxd_s;
  logic                  byte_done, stop_bad;

  // Two-flop synchronizer on the asynchronous pin; runs every clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxd_s <= sync1;
    end
  end

  // Receiver state, counters and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
    end else begin
      state      <= state_n;
      sample_cnt <= sample_n;
      bit_cnt    <= bit_n;
      shift      <= shift_n;
    end
  end

  // Next-state logic; everything advances only on rx_en.
  always_comb begin
    state_n   = state;
    sample_n  = sample_cnt;
    bit_n     = bit_cnt;
    shift_n   = shift;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    if (rx_en) begin
      case (state)
        S_IDLE: begin
          if (!rxd_s) begin
            state_n  = S_START;
            sample_n = '0;
          end
        end
        S_START: begin
          if (sample_cnt == HALF_M1) begin
            sample_n = '0;
            if (!rxd_s) begin
              state_n = S_DATA;
              bit_n   = '0;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            sample_n = sample_cnt + SW'(1);
          end
        end
        S_DATA: begin
          sample_n = sample_cnt + SW'(1);
          if (sample_cnt == FULL_M1) begin
            shift_n = {rxd_s, shift[DATABITS-1:1]};
            bit_n   = bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) state_n = S_STOP;
          end
        end
        S_STOP: begin
          sample_n = sample_cnt + SW'(1);
          if (sample_cnt == FULL_M1) begin
            if (rxd_s) begin
              byte_done = 1'b1;
              state_n   = S_IDLE;
            end else begin
              stop_bad  = 1'b1;
              state_n   = S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rxd_s) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Holding register and handshake; a completing byte takes priority over ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      data_ready <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (byte_done) begin
        data_out   <= shift;
        data_ready <= 1'b1;
        overrun    <= data_ready & ~data_ack;
      end else if (data_ack && data_ready) begin
        data_ready <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule
